regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised architectural register file with per-register busy/owner scoreboard for the out-of-order core.
- Dispatch allocates registers (sets busy plus owner tag). Retirement writes values and clears busy only when the retiring tag still owns the register.
- The instruction buffer reads value/busy/owner through NUM_RD registered read ports.
- Successor to the fixed 8-read/3-write file: adds reset, allocation, tag-checked busy release, flush, and optional same-cycle bypass.

Parameters:
NUM_REGS, 16, number of architectural registers (power of two, >=2)
DATA_W, 16, register value width
TAG_W, 4, owner tag width (ROB index)
NUM_RD, 8, read ports
NUM_WR, 3, retirement write ports
NUM_ALLOC, 2, dispatch allocation ports
Derived: AW = $clog2(NUM_REGS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rd_en[0:NUM_RD-1]  in  1  read enable per port
rd_addr[0:NUM_RD-1]  in  AW  read register index
rd_value[0:NUM_RD-1]  out  DATA_W  registered value
rd_busy[0:NUM_RD-1]  out  1  registered busy flag
rd_owner[0:NUM_RD-1]  out  TAG_W  registered owner tag
alloc_en[0:NUM_ALLOC-1]  in  1  dispatch allocation valid
alloc_reg[0:NUM_ALLOC-1]  in  AW  destination register
alloc_tag[0:NUM_ALLOC-1]  in  TAG_W  new owner tag
wr_en[0:NUM_WR-1]  in  1  retirement write valid
wr_reg[0:NUM_WR-1]  in  AW  target register
wr_tag[0:NUM_WR-1]  in  TAG_W  retiring instruction tag
wr_data[0:NUM_WR-1]  in  DATA_W  retirement value
flush  in  1  pipeline flush: clear all busy flags

Behaviour:
- Reset (async assert, sync release): all values=0, busy=0, owner=0; all rd_value/rd_busy/rd_owner=0.
- Read: 1-cycle latency. When rd_en[i]=1 at edge N, the outputs after edge N hold the state as it was before edge N's updates (no bypass). When rd_en[i]=0, outputs hold their previous value.
- Retirement write: wr_en[j] always updates values[wr_reg[j]]. If several ports target the same reg, the highest j wins (youngest retirement).
- Busy release: clear busy[r] iff some wr_en[j] has wr_reg[j]=r, busy[r]=1 and owner[r]=wr_tag[j], and no alloc to r this cycle. A stale tag writes the value but leaves busy/owner unchanged.
- Allocation: alloc_en[k] sets busy[r]=1 and owner[r]=alloc_tag[k]. If several ports target the same reg, the highest k wins (program order).
- Alloc and release of the same reg in the same cycle: alloc wins (busy=1, new owner). The value is still written.
- Flush: clears every busy bit and ignores same-cycle allocs. Same-cycle writes still update values. Owners are left unchanged.
- Out-of-range indices are impossible by construction (AW bits).
- Reset asserted mid-operation discards all same-cycle alloc and write inputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: each read port forwards same-cycle updates. rd_value takes the winning wr_data for rd_addr. rd_busy/rd_owner reflect the post-update alloc/release/flush result. Outputs therefore equal the register state after the edge.
- Undefined: pre-update semantics as above. No forwarding muxes are synthesised.

Decomposition:
- Package regfile_pkg holds:
  - default parameter constants;
  - a reg_entry_t struct {value, busy, owner};
  - a function for highest-index-wins port selection.
- One natural sub-module: regfile_next_state. It is combinational and computes next value/busy/owner per register from the write/alloc/flush vectors. The top holds the storage flops and read registers, and reuses the sub-module outputs for the bypass path.

Test Plan:
- Reset: assert rst mid-run → all read outputs 0. After release, a read of r5 → value 0, busy 0, owner 0.
- Alloc then retire: alloc r3 tag 7; next cycle write r3 tag 7 data 0xBEEF → read r3 gives 0xBEEF, busy 0. Write with stale tag 2 → value updated, busy stays 1, owner 7.
- Conflicts: wr ports 0 and 2 both write r1 (0x1111, 0x2222) → r1=0x2222. Alloc ports 0 and 1 both target r4 (tags 3, 9) → owner 9.
- Alloc/release collision: r6 busy owner 5; same cycle write r6 tag 5 plus alloc r6 tag 8 → busy 1, owner 8, value written.
- Flush: busy on r0, r2, r15 plus a same-cycle alloc of r7 → all busy 0 next cycle, owners unchanged.
- Read timing: write r2=0x00AA and read r2 the same cycle → 0x00AA is visible next cycle only with REGFILE_BYPASS_EN, otherwise the old value. With rd_en low, outputs hold.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared constants, register entry type and port-priority helper
//            for the register file with busy/owner scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_NUM_REGS  = 16;
    localparam int c_DATA_W    = 16;
    localparam int c_TAG_W     = 4;
    localparam int c_NUM_RD    = 8;
    localparam int c_NUM_WR    = 3;
    localparam int c_NUM_ALLOC = 2;

    // Widest hit vector the priority helper accepts (write and alloc ports).
    localparam int c_MAX_PORTS = 32;

    typedef struct packed {
        logic [c_DATA_W-1:0] value;
        logic                busy;
        logic [c_TAG_W-1:0]  owner;
    } reg_entry_t;

    // True when port p hits and no higher-numbered port hits, so the
    // highest index wins a same-register conflict.
    function automatic logic is_top_hit(input logic [c_MAX_PORTS-1:0] hits,
                                        input int p);
        return (hits >> p) == {{(c_MAX_PORTS-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_next_state.sv
`default_nettype none
// ============================================================================
// Module   : regfile_next_state
// Brief    : Combinational next value/busy/owner for every register, from the
//            retirement write, dispatch allocation and flush inputs.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_next_state
    import regfile_pkg::*;
#(
    parameter int NUM_REGS  = c_NUM_REGS,
    parameter int DATA_W    = c_DATA_W,
    parameter int TAG_W     = c_TAG_W,
    parameter int NUM_WR    = c_NUM_WR,
    parameter int NUM_ALLOC = c_NUM_ALLOC,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic [DATA_W-1:0] i_cur_value [0:NUM_REGS-1],
    input  logic [NUM_REGS-1:0] i_cur_busy,
    input  logic [TAG_W-1:0]  i_cur_owner [0:NUM_REGS-1],
    input  logic              i_wr_en     [0:NUM_WR-1],
    input  logic [AW-1:0]     i_wr_reg    [0:NUM_WR-1],
    input  logic [TAG_W-1:0]  i_wr_tag    [0:NUM_WR-1],
    input  logic [DATA_W-1:0] i_wr_data   [0:NUM_WR-1],
    input  logic              i_alloc_en  [0:NUM_ALLOC-1],
    input  logic [AW-1:0]     i_alloc_reg [0:NUM_ALLOC-1],
    input  logic [TAG_W-1:0]  i_alloc_tag [0:NUM_ALLOC-1],
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_nxt_value [0:NUM_REGS-1],
    output logic [NUM_REGS-1:0] o_nxt_busy,
    output logic [TAG_W-1:0]  o_nxt_owner [0:NUM_REGS-1]
);

    logic [c_MAX_PORTS-1:0] w_wr_hit;
    logic [c_MAX_PORTS-1:0] w_al_hit;
    logic                   w_release;

    // Per register: youngest write supplies the value, a matching-tag write
    // releases busy, and allocation (last in program order) overrides release.
    always_comb begin
        w_wr_hit   = '0;
        w_al_hit   = '0;
        w_release  = 1'b0;
        o_nxt_busy = i_cur_busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_wr_hit       = '0;
            w_al_hit       = '0;
            w_release      = 1'b0;
            o_nxt_value[r] = i_cur_value[r];
            o_nxt_owner[r] = i_cur_owner[r];

            for (int j = 0; j < NUM_WR; j++) begin
                w_wr_hit[j] = i_wr_en[j] && (i_wr_reg[j] == r[AW-1:0]);
                if (w_wr_hit[j] && i_cur_busy[r] && (i_cur_owner[r] == i_wr_tag[j]))
                    w_release = 1'b1;
            end
            for (int j = 0; j < NUM_WR; j++) begin
                if (is_top_hit(w_wr_hit, j))
                    o_nxt_value[r] = i_wr_data[j];
            end

            for (int k = 0; k < NUM_ALLOC; k++) begin
                w_al_hit[k] = i_alloc_en[k] && (i_alloc_reg[k] == r[AW-1:0]);
            end
            if (!i_flush) begin
                for (int k = 0; k < NUM_ALLOC; k++) begin
                    if (is_top_hit(w_al_hit, k))
                        o_nxt_owner[r] = i_alloc_tag[k];
                end
            end

            // Flush drops every busy bit and suppresses same-cycle allocations.
            if (i_flush)
                o_nxt_busy[r] = 1'b0;
            else if (|w_al_hit)
                o_nxt_busy[r] = 1'b1;
            else if (w_release)
                o_nxt_busy[r] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Architectural register file with per-register busy/owner
//            scoreboard, NUM_RD registered read ports, NUM_WR retirement
//            write ports, NUM_ALLOC dispatch allocation ports and flush.
//            Optional macro REGFILE_BYPASS_EN: read ports return the
//            post-update register state instead of the pre-update state.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS  = c_NUM_REGS,
    parameter int DATA_W    = c_DATA_W,
    parameter int TAG_W     = c_TAG_W,
    parameter int NUM_RD    = c_NUM_RD,
    parameter int NUM_WR    = c_NUM_WR,
    parameter int NUM_ALLOC = c_NUM_ALLOC,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en     [0:NUM_RD-1],
    input  logic [AW-1:0]     rd_addr   [0:NUM_RD-1],
    output logic [DATA_W-1:0] rd_value  [0:NUM_RD-1],
    output logic              rd_busy   [0:NUM_RD-1],
    output logic [TAG_W-1:0]  rd_owner  [0:NUM_RD-1],
    input  logic              alloc_en  [0:NUM_ALLOC-1],
    input  logic [AW-1:0]     alloc_reg [0:NUM_ALLOC-1],
    input  logic [TAG_W-1:0]  alloc_tag [0:NUM_ALLOC-1],
    input  logic              wr_en     [0:NUM_WR-1],
    input  logic [AW-1:0]     wr_reg    [0:NUM_WR-1],
    input  logic [TAG_W-1:0]  wr_tag    [0:NUM_WR-1],
    input  logic [DATA_W-1:0] wr_data   [0:NUM_WR-1],
    input  logic              flush
);

    logic [DATA_W-1:0]   r_value    [0:NUM_REGS-1];
    logic [NUM_REGS-1:0] r_busy;
    logic [TAG_W-1:0]    r_owner    [0:NUM_REGS-1];

    logic [DATA_W-1:0]   w_nxt_value [0:NUM_REGS-1];
    logic [NUM_REGS-1:0] w_nxt_busy;
    logic [TAG_W-1:0]    w_nxt_owner [0:NUM_REGS-1];

    logic [DATA_W-1:0]   r_rd_value [0:NUM_RD-1];
    logic                r_rd_busy  [0:NUM_RD-1];
    logic [TAG_W-1:0]    r_rd_owner [0:NUM_RD-1];

    regfile_next_state #(
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .TAG_W     (TAG_W),
        .NUM_WR    (NUM_WR),
        .NUM_ALLOC (NUM_ALLOC)
    ) u_next_state (
        .i_cur_value (r_value),
        .i_cur_busy  (r_busy),
        .i_cur_owner (r_owner),
        .i_wr_en     (wr_en),
        .i_wr_reg    (wr_reg),
        .i_wr_tag    (wr_tag),
        .i_wr_data   (wr_data),
        .i_alloc_en  (alloc_en),
        .i_alloc_reg (alloc_reg),
        .i_alloc_tag (alloc_tag),
        .i_flush     (flush),
        .o_nxt_value (w_nxt_value),
        .o_nxt_busy  (w_nxt_busy),
        .o_nxt_owner (w_nxt_owner)
    );

    // Register storage: every entry takes its computed next state each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                r_value[r] <= '0;
                r_owner[r] <= '0;
            end
        end else begin
            r_busy <= w_nxt_busy;
            for (int r = 0; r < NUM_REGS; r++) begin
                r_value[r] <= w_nxt_value[r];
                r_owner[r] <= w_nxt_owner[r];
            end
        end
    end

    // Read ports: capture the addressed entry when enabled, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RD; i++) begin
                r_rd_value[i] <= '0;
                r_rd_busy[i]  <= 1'b0;
                r_rd_owner[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
`ifdef REGFILE_BYPASS_EN
                    r_rd_value[i] <= w_nxt_value[rd_addr[i]];
                    r_rd_busy[i]  <= w_nxt_busy[rd_addr[i]];
                    r_rd_owner[i] <= w_nxt_owner[rd_addr[i]];
`else
                    r_rd_value[i] <= r_value[rd_addr[i]];
                    r_rd_busy[i]  <= r_busy[rd_addr[i]];
                    r_rd_owner[i] <= r_owner[rd_addr[i]];
`endif
                end
            end
        end
    end

    assign rd_value = r_rd_value;
    assign rd_busy  = r_rd_busy;
    assign rd_owner = r_rd_owner;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Scoreboard bench for regfile_scoreboard. Read requests push the
//            hand-computed expected entry; a monitor pops and compares one
//            cycle later and checks that idle ports hold their last value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int NR = 16;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam int RD = 8;
    localparam int WR = 3;
    localparam int AL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en     [0:RD-1];
    logic [3:0]    rd_addr   [0:RD-1];
    logic [DW-1:0] rd_value  [0:RD-1];
    logic          rd_busy   [0:RD-1];
    logic [TW-1:0] rd_owner  [0:RD-1];
    logic          alloc_en  [0:AL-1];
    logic [3:0]    alloc_reg [0:AL-1];
    logic [TW-1:0] alloc_tag [0:AL-1];
    logic          wr_en     [0:WR-1];
    logic [3:0]    wr_reg    [0:WR-1];
    logic [TW-1:0] wr_tag    [0:WR-1];
    logic [DW-1:0] wr_data   [0:WR-1];
    logic          flush;

    typedef struct {
        int         port;
        reg_entry_t ent;
        string      name;
    } exp_t;

    exp_t       q[$];
    reg_entry_t last_exp [0:RD-1];
    int         n_cmp = 0;
    int         n_bad = 0;

    regfile_scoreboard u_dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_value  (rd_value),
        .rd_busy   (rd_busy),
        .rd_owner  (rd_owner),
        .alloc_en  (alloc_en),
        .alloc_reg (alloc_reg),
        .alloc_tag (alloc_tag),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_tag    (wr_tag),
        .wr_data   (wr_data),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        for (int i = 0; i < RD; i++) begin rd_en[i] = 1'b0; rd_addr[i] = '0; end
        for (int k = 0; k < AL; k++) begin alloc_en[k] = 1'b0; alloc_reg[k] = '0; alloc_tag[k] = '0; end
        for (int j = 0; j < WR; j++) begin wr_en[j] = 1'b0; wr_reg[j] = '0; wr_tag[j] = '0; wr_data[j] = '0; end
        flush = 1'b0;
    endtask

    // Inputs change on the falling edge; the DUT samples them on the rising edge.
    task automatic tick();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic rd(input int p, input logic [3:0] a, input logic [DW-1:0] v,
                      input logic b, input logic [TW-1:0] o, input string nm);
        exp_t e;
        rd_en[p]      = 1'b1;
        rd_addr[p]    = a;
        e.port        = p;
        e.ent.value   = v;
        e.ent.busy    = b;
        e.ent.owner   = o;
        e.name        = nm;
        q.push_back(e);
    endtask

    task automatic alloc(input int k, input logic [3:0] r, input logic [TW-1:0] t);
        alloc_en[k] = 1'b1; alloc_reg[k] = r; alloc_tag[k] = t;
    endtask

    task automatic wr(input int j, input logic [3:0] r, input logic [TW-1:0] t,
                      input logic [DW-1:0] d);
        wr_en[j] = 1'b1; wr_reg[j] = r; wr_tag[j] = t; wr_data[j] = d;
    endtask

    function automatic void check(input string nm, input int p, input reg_entry_t exp);
        reg_entry_t got;
        got.value = rd_value[p];
        got.busy  = rd_busy[p];
        got.owner = rd_owner[p];
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s port%0d: got value=%h busy=%b owner=%h, expected value=%h busy=%b owner=%h",
                     nm, p, got.value, got.busy, got.owner, exp.value, exp.busy, exp.owner);
        end
    endfunction

    // Monitor: one cycle after each edge, enabled ports present a result.
    initial begin : p_monitor
        logic [RD-1:0] issued;
        logic          rst_seen;
        exp_t          e;
        reg_entry_t    zero;
        zero = '0;
        for (int p = 0; p < RD; p++) last_exp[p] = '0;
        forever begin
            @(posedge clk);
            for (int p = 0; p < RD; p++) issued[p] = rd_en[p];
            rst_seen = rst;
            #1;
            if (rst_seen || rst) begin
                for (int p = 0; p < RD; p++) begin
                    check("reset", p, zero);
                    last_exp[p] = '0;
                end
            end else begin
                for (int p = 0; p < RD; p++) begin
                    if (issued[p]) begin
                        if (q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL scoreboard_underflow port%0d: got read with no expected entry, required a queued entry", p);
                        end else begin
                            e = q.pop_front();
                            check(e.name, p, e.ent);
                            last_exp[p] = e.ent;
                        end
                    end else begin
                        check("hold", p, last_exp[p]);
                    end
                end
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Fresh state after reset.
        rd(5, 4'd5, 16'h0000, 1'b0, 4'h0, "post_reset_r5"); tick();

        // Allocate, then retire with the owning tag.
        alloc(0, 4'd3, 4'h7); tick();
        wr(1, 4'd3, 4'h7, 16'hBEEF); tick();
        rd(0, 4'd3, 16'hBEEF, 1'b0, 4'h7, "retire_match"); tick();

        // Stale tag: value lands, busy/owner stay.
        alloc(0, 4'd3, 4'h7); tick();
        wr(0, 4'd3, 4'h2, 16'h1234); tick();
        rd(0, 4'd3, 16'h1234, 1'b1, 4'h7, "retire_stale"); tick();

        // Port conflicts: highest index wins.
        wr(0, 4'd1, 4'h0, 16'h1111); wr(2, 4'd1, 4'h0, 16'h2222); tick();
        alloc(0, 4'd4, 4'h3); alloc(1, 4'd4, 4'h9); tick();
        rd(1, 4'd1, 16'h2222, 1'b0, 4'h0, "wr_conflict");
        rd(2, 4'd4, 16'h0000, 1'b1, 4'h9, "alloc_conflict"); tick();

        // Alloc and release of the same register in one cycle.
        alloc(0, 4'd6, 4'h5); tick();
        wr(0, 4'd6, 4'h5, 16'h6666); alloc(1, 4'd6, 4'h8); tick();
        rd(3, 4'd6, 16'h6666, 1'b1, 4'h8, "alloc_vs_release"); tick();

        // Flush with a same-cycle alloc (ignored) and write (kept).
        alloc(0, 4'd0, 4'h1); alloc(1, 4'd2, 4'h2); tick();
        alloc(0, 4'd15, 4'hF); tick();
        flush = 1'b1; alloc(0, 4'd7, 4'hA); wr(0, 4'd1, 4'h0, 16'h3333); tick();
        rd(0, 4'd0,  16'h0000, 1'b0, 4'h1, "flush_r0");
        rd(1, 4'd2,  16'h0000, 1'b0, 4'h2, "flush_r2");
        rd(2, 4'd15, 16'h0000, 1'b0, 4'hF, "flush_r15");
        rd(3, 4'd7,  16'h0000, 1'b0, 4'h0, "flush_r7");
        rd(4, 4'd3,  16'h1234, 1'b0, 4'h7, "flush_r3");
        rd(5, 4'd4,  16'h0000, 1'b0, 4'h9, "flush_r4");
        rd(6, 4'd6,  16'h6666, 1'b0, 4'h8, "flush_r6");
        rd(7, 4'd1,  16'h3333, 1'b0, 4'h0, "flush_wr_r1"); tick();

        // Read in the same cycle as a write to the same register.
        wr(0, 4'd2, 4'h0, 16'h00AA);
`ifdef REGFILE_BYPASS_EN
        rd(4, 4'd2, 16'h00AA, 1'b0, 4'h2, "same_cycle_read");
`else
        rd(4, 4'd2, 16'h0000, 1'b0, 4'h2, "same_cycle_read");
`endif
        tick();
        rd(4, 4'd2, 16'h00AA, 1'b0, 4'h2, "next_cycle_read"); tick();
        tick(); tick();

        // Reset mid-run discards the same-cycle alloc/write.
        alloc(0, 4'd9, 4'h3); wr(0, 4'd9, 4'h3, 16'h9999);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        rd(0, 4'd9, 16'h0000, 1'b0, 4'h0, "reset_discard_r9");
        rd(1, 4'd3, 16'h0000, 1'b0, 4'h0, "reset_clear_r3"); tick();
        tick(); tick();

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
